debug_word_serializer: RTL

DEBUG_WORD_SERIALIZER -- requirements
Module: debug_word_serializer

---
 rtl/debug_word_serializer.sv | 132 +++++++++++++
 1 files changed

// File: rtl/debug_word_serializer.sv
// Queues debug words in a small circular FIFO and presents each one as a series of
// chunks to a byte- or bit-serial consumer, advancing one chunk per i_chunk_done.
module debug_word_serializer #(
  parameter int DATA_WIDTH  = 32,
  parameter int CHUNK_WIDTH = 8,
  parameter int DEPTH       = 4,
  parameter bit MSB_FIRST   = 1'b0
) (
  input  logic                           i_clk,
  input  logic                           i_reset_n,
  input  logic                           i_load,
  input  logic [DATA_WIDTH-1:0]          i_data,
  input  logic                           i_chunk_done,
  input  logic                           i_clear_overflow,
  output logic [CHUNK_WIDTH-1:0]         o_chunk,
  output logic                           o_chunk_valid,
  output logic                           o_last_chunk,
  output logic                           o_full,
  output logic                           o_empty,
  output logic [$clog2(DEPTH+1)-1:0]     o_words_pending,
  output logic                           o_overflow
);

  // state   | meaning
  // S_IDLE  | no word in flight, waiting for the FIFO to become non-empty
  // S_FETCH | FIFO head is popped into the active register this edge
  // S_SEND  | active word presented one chunk at a time, o_chunk_valid=1

  localparam int N_CHUNKS = DATA_WIDTH / CHUNK_WIDTH;
  localparam int PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W    = $clog2(DEPTH + 1);
  localparam int IDX_W    = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_CHUNKS - 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_SEND} state_t;

  state_t                  state;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic [CNT_W-1:0]        count;
  logic [DATA_WIDTH-1:0]   active;
  logic [IDX_W-1:0]        chunk_idx;
  logic                    overflow;

  logic                    fifo_full;
  logic                    fifo_nonempty;
  logic                    on_last;
  logic                    wr_en;
  logic                    pop;
  logic [DATA_WIDTH-1:0]   active_shifted;
  logic [CHUNK_WIDTH-1:0]  head_chunk;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign fifo_full     = (count == CNT_FULL);
  assign fifo_nonempty = (count != '0);
  assign on_last       = (chunk_idx == IDX_LAST);

  // A full FIFO refuses the load even when a pop frees a slot on the same edge.
  assign wr_en = i_load && !fifo_full;
  assign pop   = (state == S_FETCH) ||
                 ((state == S_SEND) && i_chunk_done && on_last && fifo_nonempty);

  assign active_shifted = MSB_FIRST ? (active << CHUNK_WIDTH) : (active >> CHUNK_WIDTH);
  assign head_chunk     = MSB_FIRST ? active[DATA_WIDTH-1 -: CHUNK_WIDTH]
                                    : active[CHUNK_WIDTH-1:0];

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state     <= S_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      active    <= '0;
      chunk_idx <= '0;
      overflow  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= i_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CNT_W'(wr_en) - CNT_W'(pop);

      if (i_load && fifo_full)   overflow <= 1'b1;
      else if (i_clear_overflow) overflow <= 1'b0;

      case (state)
        S_IDLE: begin
          if (fifo_nonempty) state <= S_FETCH;
        end
        S_FETCH: begin
          active    <= mem[rd_ptr];
          chunk_idx <= '0;
          state     <= S_SEND;
        end
        S_SEND: begin
          if (i_chunk_done) begin
            if (!on_last) begin
              active    <= active_shifted;
              chunk_idx <= chunk_idx + 1'b1;
            end else if (fifo_nonempty) begin
              active    <= mem[rd_ptr];
              chunk_idx <= '0;
            end else begin
              active    <= '0;
              chunk_idx <= '0;
              state     <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign o_chunk_valid   = (state == S_SEND);
  assign o_chunk         = o_chunk_valid ? head_chunk : '0;
  assign o_last_chunk    = o_chunk_valid && on_last;
  assign o_full          = fifo_full;
  assign o_empty         = !fifo_nonempty && (state == S_IDLE);
  assign o_words_pending = count;
  assign o_overflow      = overflow;

endmodule
